// File: rtl/alu_pkg.sv
// Shared constants, types and forwarding helper for the ALU issue stage.
//   Opcodes, funct3/funct7 constants, ALU operation codes, the operand-1
//   source select and the packed ID/EX slot payload.
package alu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned ALU_OP_W = 4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    SRC1_RS1  = 2'd0,
    SRC1_ZERO = 2'd1,
    SRC1_PC   = 2'd2
  } src1_e;

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic                is_load;
    logic                is_store;
    logic                illegal;
    logic [REG_W-1:0]    rd;
    logic [ALU_OP_W-1:0] op;
    logic [XLEN-1:0]     data1;
    logic [XLEN-1:0]     data2;
    logic [XLEN-1:0]     store_data;
  } ex_slot_t;

  // Operand forwarding: held slot > MEM > WB > register file; x0 is always 0.
  function automatic logic [XLEN-1:0] fwd_select(
    input logic [REG_W-1:0] rs,
    input logic [XLEN-1:0]  rf_data,
    input logic             held_en,
    input logic [REG_W-1:0] held_rd,
    input logic [XLEN-1:0]  held_data,
    input logic             mem_en,
    input logic [REG_W-1:0] mem_rd,
    input logic [XLEN-1:0]  mem_data,
    input logic             wb_en,
    input logic [REG_W-1:0] wb_rd,
    input logic [XLEN-1:0]  wb_data
  );
    logic [XLEN-1:0] r;
    if (rs == REG_W'(0))                  r = '0;
    else if (held_en && (held_rd == rs))  r = held_data;
    else if (mem_en && (mem_rd == rs))    r = mem_data;
    else if (wb_en && (wb_rd == rs))      r = wb_data;
    else                                  r = rf_data;
    return r;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational instruction decoder for the ALU issue stage.
//   in : opcode, funct3, funct7
//   out: op_c (ALU code), src1_c (operand-1 source), src2_imm_c (operand-2 is IMM),
//        uses_rs1_c, uses_rs2_c, is_load_c, is_store_c, illegal_c
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  output logic [ALU_OP_W-1:0] op_c,
  output src1_e               src1_c,
  output logic                src2_imm_c,
  output logic                uses_rs1_c,
  output logic                uses_rs2_c,
  output logic                is_load_c,
  output logic                is_store_c,
  output logic                illegal_c
);

  always_comb begin
    op_c       = ALU_ADD;
    src1_c     = SRC1_RS1;
    src2_imm_c = 1'b0;
    uses_rs1_c = 1'b0;
    uses_rs2_c = 1'b0;
    is_load_c  = 1'b0;
    is_store_c = 1'b0;
    illegal_c  = 1'b0;

    case (opcode)
      OP_R: begin
        uses_rs1_c = 1'b1;
        uses_rs2_c = 1'b1;
        if ((funct3 == F3_ADD) && (funct7 == F7_BASE))      op_c = ALU_ADD;
        else if ((funct3 == F3_ADD) && (funct7 == F7_SUB))  op_c = ALU_SUB;
        else if ((funct3 == F3_AND) && (funct7 == F7_BASE)) op_c = ALU_AND;
        else if ((funct3 == F3_OR) && (funct7 == F7_BASE))  op_c = ALU_OR;
        else                                                illegal_c = 1'b1;
      end
      OP_I: begin
        uses_rs1_c = 1'b1;
        src2_imm_c = 1'b1;
        case (funct3)
          F3_ADD:  op_c = ALU_ADD;
          F3_AND:  op_c = ALU_AND;
          F3_OR:   op_c = ALU_OR;
          default: illegal_c = 1'b1;
        endcase
      end
      OP_LOAD: begin
        uses_rs1_c = 1'b1;
        src2_imm_c = 1'b1;
        is_load_c  = 1'b1;
      end
      OP_STORE: begin
        uses_rs1_c = 1'b1;
        uses_rs2_c = 1'b1;
        src2_imm_c = 1'b1;
        is_store_c = 1'b1;
      end
      OP_LUI: begin
        src1_c     = SRC1_ZERO;
        src2_imm_c = 1'b1;
      end
      OP_AUIPC: begin
        src1_c     = SRC1_PC;
        src2_imm_c = 1'b1;
      end
      default: illegal_c = 1'b1;
    endcase

    // An illegal instruction is dropped, so it reads nothing and cannot stall.
    if (illegal_c) begin
      uses_rs1_c = 1'b0;
      uses_rs2_c = 1'b0;
      is_load_c  = 1'b0;
      is_store_c = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register and issue logic in front of the 32-bit integer ALU.
//   ID side : id_valid/id_ready handshake, decoded fields, register-file data, immediate
//   Fwd     : alu_result (held slot), fwd_mem_*, fwd_wb_* writeback sources
//   EX side : ex_valid/ex_ready, data1/data2/alu_operation, ex_rd, ex_reg_write,
//             ex_is_load, ex_is_store, ex_store_data, illegal (one-cycle pulse)
//   flush   : synchronous kill of the held slot; reset is async active-high.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [6:0]          id_opcode,
  input  logic [2:0]          id_funct3,
  input  logic [6:0]          id_funct7,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic [REG_W-1:0]    id_rd,
  input  logic [XLEN-1:0]     id_rs1_data,
  input  logic [XLEN-1:0]     id_rs2_data,
  input  logic [XLEN-1:0]     id_imm,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                fwd_mem_valid,
  input  logic [REG_W-1:0]    fwd_mem_rd,
  input  logic [XLEN-1:0]     fwd_mem_data,
  input  logic                fwd_wb_valid,
  input  logic [REG_W-1:0]    fwd_wb_rd,
  input  logic [XLEN-1:0]     fwd_wb_data,
  input  logic                ex_ready,
  input  logic                flush,
  output logic                ex_valid,
  output logic [XLEN-1:0]     data1,
  output logic [XLEN-1:0]     data2,
  output logic [ALU_OP_W-1:0] alu_operation,
  output logic [REG_W-1:0]    ex_rd,
  output logic                ex_reg_write,
  output logic                ex_is_load,
  output logic                ex_is_store,
  output logic [XLEN-1:0]     ex_store_data,
  output logic                illegal
);

  ex_slot_t slot, slot_d;

  logic [ALU_OP_W-1:0] dec_op;
  src1_e               dec_src1;
  logic                dec_src2_imm;
  logic                dec_uses_rs1;
  logic                dec_uses_rs2;
  logic                dec_is_load;
  logic                dec_is_store;
  logic                dec_illegal;

  alu_op_decoder u_dec (
    .opcode     (id_opcode),
    .funct3     (id_funct3),
    .funct7     (id_funct7),
    .op_c       (dec_op),
    .src1_c     (dec_src1),
    .src2_imm_c (dec_src2_imm),
    .uses_rs1_c (dec_uses_rs1),
    .uses_rs2_c (dec_uses_rs2),
    .is_load_c  (dec_is_load),
    .is_store_c (dec_is_store),
    .illegal_c  (dec_illegal)
  );

  // Held slot can forward only once its value is known (not a pending load).
  logic held_fwd_en;
  logic load_pending;
  logic hazard;
  logic capture;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd, op1_val, op2_val;

  assign held_fwd_en  = slot.valid && slot.reg_write && !slot.is_load;
  assign load_pending = slot.valid && slot.reg_write && slot.is_load;

  assign rs1_fwd = fwd_select(id_rs1, id_rs1_data, held_fwd_en, slot.rd, alu_result,
                              fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                              fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
  assign rs2_fwd = fwd_select(id_rs2, id_rs2_data, held_fwd_en, slot.rd, alu_result,
                              fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                              fwd_wb_valid, fwd_wb_rd, fwd_wb_data);

  // reg_write implies rd != 0, so an x0 source never raises a hazard.
  assign hazard = load_pending &&
                  ((dec_uses_rs1 && (slot.rd == id_rs1)) ||
                   (dec_uses_rs2 && (slot.rd == id_rs2)));

  assign id_ready = !flush && !hazard && (!slot.valid || ex_ready);
  assign capture  = id_valid && id_ready;

  // Operand muxes.
  always_comb begin
    case (dec_src1)
      SRC1_ZERO: op1_val = '0;
      SRC1_PC:   op1_val = id_pc;
      default:   op1_val = rs1_fwd;
    endcase
    op2_val = dec_src2_imm ? id_imm : rs2_fwd;
  end

  // Next slot: flush > capture > bubble (ex_ready) > hold. A bubble clears only
  // the control flags; operand fields keep their last values.
  always_comb begin
    slot_d         = slot;
    slot_d.illegal = 1'b0;
    if (flush || (!capture && ex_ready)) begin
      slot_d.valid     = 1'b0;
      slot_d.reg_write = 1'b0;
      slot_d.is_load   = 1'b0;
      slot_d.is_store  = 1'b0;
    end else if (capture) begin
      if (dec_illegal) begin
        slot_d.valid     = 1'b0;
        slot_d.reg_write = 1'b0;
        slot_d.is_load   = 1'b0;
        slot_d.is_store  = 1'b0;
        slot_d.illegal   = 1'b1;
      end else begin
        slot_d.valid      = 1'b1;
        slot_d.reg_write  = !dec_is_store && (id_rd != REG_W'(0));
        slot_d.is_load    = dec_is_load;
        slot_d.is_store   = dec_is_store;
        slot_d.rd         = id_rd;
        slot_d.op         = dec_op;
        slot_d.data1      = op1_val;
        slot_d.data2      = op2_val;
        slot_d.store_data = rs2_fwd;
      end
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) slot <= '0;
    else       slot <= slot_d;
  end

  assign ex_valid      = slot.valid;
  assign data1         = slot.data1;
  assign data2         = slot.data2;
  assign alu_operation = slot.op;
  assign ex_rd         = slot.rd;
  assign ex_reg_write  = slot.reg_write;
  assign ex_is_load    = slot.is_load;
  assign ex_is_store   = slot.is_store;
  assign ex_store_data = slot.store_data;
  assign illegal       = slot.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: behavioural reference model, an
// every-cycle compare process, directed literal checks and random stimulus.
module tb_alu_issue_stage;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [31:0] alu_result;
  logic        fwd_mem_valid;
  logic [4:0]  fwd_mem_rd;
  logic [31:0] fwd_mem_data;
  logic        fwd_wb_valid;
  logic [4:0]  fwd_wb_rd;
  logic [31:0] fwd_wb_data;
  logic        ex_ready;
  logic        flush;
  logic        ex_valid;
  logic [31:0] data1, data2;
  logic [3:0]  alu_operation;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_is_load, ex_is_store;
  logic [31:0] ex_store_data;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  alu_issue_stage dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_opcode     (id_opcode),
    .id_funct3     (id_funct3),
    .id_funct7     (id_funct7),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_rs1_data   (id_rs1_data),
    .id_rs2_data   (id_rs2_data),
    .id_imm        (id_imm),
    .alu_result    (alu_result),
    .fwd_mem_valid (fwd_mem_valid),
    .fwd_mem_rd    (fwd_mem_rd),
    .fwd_mem_data  (fwd_mem_data),
    .fwd_wb_valid  (fwd_wb_valid),
    .fwd_wb_rd     (fwd_wb_rd),
    .fwd_wb_data   (fwd_wb_data),
    .ex_ready      (ex_ready),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .data1         (data1),
    .data2         (data2),
    .alu_operation (alu_operation),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_is_load    (ex_is_load),
    .ex_is_store   (ex_is_store),
    .ex_store_data (ex_store_data),
    .illegal       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit       ok;
    bit [3:0] op;
    int       a_src;   // 0 rs1, 1 zero, 2 pc
    bit       b_imm;
    bit       r1;
    bit       r2;
    bit       ld;
    bit       st;
  } dec_t;

  logic        m_valid, m_rw, m_ld, m_st, m_ill;
  logic [4:0]  m_rd;
  logic [3:0]  m_op;
  logic [31:0] m_d1, m_d2, m_sd;

  function automatic dec_t ref_decode(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic [6:0] f7);
    dec_t d;
    d.ok = 1; d.op = 4'b0010; d.a_src = 0; d.b_imm = 1;
    d.r1 = 1; d.r2 = 0; d.ld = 0; d.st = 0;
    case (opc)
      7'b0110011: begin
        d.b_imm = 0; d.r2 = 1;
        case ({f7, f3})
          10'b0000000_000: d.op = 4'b0010;
          10'b0100000_000: d.op = 4'b0110;
          10'b0000000_111: d.op = 4'b0000;
          10'b0000000_110: d.op = 4'b0001;
          default:         d.ok = 0;
        endcase
      end
      7'b0010011: begin
        case (f3)
          3'b000:  d.op = 4'b0010;
          3'b111:  d.op = 4'b0000;
          3'b110:  d.op = 4'b0001;
          default: d.ok = 0;
        endcase
      end
      7'b0000011: d.ld = 1;
      7'b0100011: begin d.st = 1; d.r2 = 1; end
      7'b0110111: begin d.a_src = 1; d.r1 = 0; end
      7'b0010111: begin d.a_src = 2; d.r1 = 0; end
      default:    d.ok = 0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0110: return a - b;
      default: return a + b;
    endcase
  endfunction

  // The ALU in front of this stage: result of the held instruction.
  assign alu_result = ref_alu(m_op, m_d1, m_d2);

  function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return 32'd0;
    if (m_valid && m_rw && !m_ld && m_rd == rs) return ref_alu(m_op, m_d1, m_d2);
    if (fwd_mem_valid && fwd_mem_rd == rs) return fwd_mem_data;
    if (fwd_wb_valid && fwd_wb_rd == rs) return fwd_wb_data;
    return rf;
  endfunction

  function automatic bit ref_ready();
    dec_t d;
    bit haz;
    d = ref_decode(id_opcode, id_funct3, id_funct7);
    haz = m_valid && m_ld && m_rw && d.ok &&
          ((d.r1 && m_rd == id_rs1) || (d.r2 && m_rd == id_rs2));
    return !flush && !haz && (!m_valid || ex_ready);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 0; m_rw <= 0; m_ld <= 0; m_st <= 0; m_ill <= 0;
      m_rd <= 0; m_op <= 0; m_d1 <= 0; m_d2 <= 0; m_sd <= 0;
    end else begin : upd
      dec_t d;
      d = ref_decode(id_opcode, id_funct3, id_funct7);
      m_ill <= 0;
      if (flush) begin
        m_valid <= 0; m_rw <= 0; m_ld <= 0; m_st <= 0;
      end else if (id_valid && ref_ready()) begin
        if (!d.ok) begin
          m_valid <= 0; m_rw <= 0; m_ld <= 0; m_st <= 0; m_ill <= 1;
        end else begin
          m_valid <= 1;
          m_rw    <= !d.st && (id_rd != 5'd0);
          m_ld    <= d.ld;
          m_st    <= d.st;
          m_rd    <= id_rd;
          m_op    <= d.op;
          m_d1    <= (d.a_src == 1) ? 32'd0 :
                     (d.a_src == 2) ? id_pc : ref_operand(id_rs1, id_rs1_data);
          m_d2    <= d.b_imm ? id_imm : ref_operand(id_rs2, id_rs2_data);
          m_sd    <= ref_operand(id_rs2, id_rs2_data);
        end
      end else if (ex_ready) begin
        m_valid <= 0; m_rw <= 0; m_ld <= 0; m_st <= 0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("ex_valid",      32'(ex_valid),      32'(m_valid));
      chk("ex_reg_write",  32'(ex_reg_write),  32'(m_rw));
      chk("ex_is_load",    32'(ex_is_load),    32'(m_ld));
      chk("ex_is_store",   32'(ex_is_store),   32'(m_st));
      chk("illegal",       32'(illegal),       32'(m_ill));
      chk("ex_rd",         32'(ex_rd),         32'(m_rd));
      chk("alu_operation", 32'(alu_operation), 32'(m_op));
      chk("data1",         data1,              m_d1);
      chk("data2",         data2,              m_d2);
      chk("ex_store_data", ex_store_data,      m_sd);
      chk("id_ready",      32'(id_ready),      32'(ref_ready()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; fwd_mem_valid = 0; fwd_wb_valid = 0; flush = 0;
  endtask

  task automatic present(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
    id_valid = 1; id_opcode = opc; id_funct3 = f3; id_funct7 = f7;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = 32'h1000;
  endtask

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;
  localparam logic [6:0] L = 7'b0000011;

  initial begin
    reset = 1; id_valid = 0; id_pc = 0; id_opcode = 0; id_funct3 = 0; id_funct7 = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    fwd_mem_valid = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
    fwd_wb_valid = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
    ex_ready = 1; flush = 0;
    repeat (3) step();
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_op",       32'(alu_operation), 0);
    chk("rst_data1",    data1, 0);
    chk("rst_illegal",  32'(illegal), 0);
    reset = 0;
    #1 chk("rst_id_ready", 32'(id_ready), 1);

    // ADD then SUB with the same operands
    present(R, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'h10, 32'h5, 0);
    step();
    chk("add_d1", data1, 32'h10);
    chk("add_d2", data2, 32'h5);
    chk("add_op", 32'(alu_operation), 32'h2);
    present(R, 3'b000, 7'h20, 5'd3, 5'd1, 5'd2, 32'h10, 32'h5, 0);
    step();
    chk("sub_op", 32'(alu_operation), 32'h6);
    chk("sub_d1", data1, 32'h10);

    // held ADD x3 (result 0x15) forwards into ORI x4,x3,0xF0 over MEM x3=0x99
    present(R, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'h10, 32'h5, 0);
    step();
    present(I, 3'b110, 7'h00, 5'd4, 5'd3, 5'd0, 32'h1234, 32'h0, 32'hF0);
    fwd_mem_valid = 1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'h99;
    step();
    chk("fwd_held_d1", data1, 32'h15);
    chk("fwd_held_d2", data2, 32'hF0);
    chk("fwd_held_op", 32'(alu_operation), 32'h1);
    idle();

    // load-use: LW x5 held, ADD x6,x5,x1 must stall one cycle
    present(L, 3'b010, 7'h00, 5'd5, 5'd1, 5'd0, 32'h100, 32'h0, 32'h4);
    step();
    chk("lw_is_load", 32'(ex_is_load), 1);
    chk("lw_d1", data1, 32'h100);
    present(R, 3'b000, 7'h00, 5'd6, 5'd5, 5'd1, 32'hEEEE, 32'h7, 0);
    fwd_mem_valid = 1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'hAB;
    #1 chk("lu_id_ready", 32'(id_ready), 0);
    step();
    chk("lu_bubble", 32'(ex_valid), 0);
    chk("lu_bubble_d1_hold", data1, 32'h100);
    chk("lu_ready_after", 32'(id_ready), 1);
    step();
    chk("lu_issue_valid", 32'(ex_valid), 1);
    chk("lu_issue_d1", data1, 32'hAB);
    chk("lu_issue_d2", data2, 32'h7);
    idle();

    // stall three cycles with an ORI waiting, then release, then flush
    ex_ready = 0;
    present(I, 3'b110, 7'h00, 5'd9, 5'd1, 5'd0, 32'h40, 32'h0, 32'h3);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_valid", 32'(ex_valid), 1);
      chk("stall_d1", data1, 32'hAB);
      chk("stall_rd", 32'(ex_rd), 6);
      chk("stall_ready", 32'(id_ready), 0);
    end
    ex_ready = 1;
    step();
    chk("post_stall_rd", 32'(ex_rd), 9);
    chk("post_stall_d1", data1, 32'h40);
    present(R, 3'b111, 7'h00, 5'd10, 5'd1, 5'd2, 32'h1, 32'h2, 0);
    flush = 1;
    #1 chk("flush_ready", 32'(id_ready), 0);
    step();
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_no_capture", 32'(ex_rd), 9);
    idle();

    // illegal opcode
    present(7'b1110011, 3'b000, 7'h00, 5'd11, 5'd1, 5'd2, 32'h1, 32'h2, 0);
    step();
    chk("ill_pulse", 32'(illegal), 1);
    chk("ill_valid", 32'(ex_valid), 0);
    idle();
    step();
    chk("ill_gone", 32'(illegal), 0);

    // ADD x0,x0,x7: x0 reads zero even with a MEM source claiming x0
    present(R, 3'b000, 7'h00, 5'd0, 5'd0, 5'd7, 32'h55, 32'h22, 0);
    fwd_mem_valid = 1; fwd_mem_rd = 5'd0; fwd_mem_data = 32'h77;
    step();
    chk("x0_d1", data1, 0);
    chk("x0_d2", data2, 32'h22);
    chk("x0_rw", 32'(ex_reg_write), 0);
    chk("x0_valid", 32'(ex_valid), 1);
    idle();

    // reset while stalled
    present(R, 3'b000, 7'h00, 5'd12, 5'd1, 5'd2, 32'h10, 32'h5, 0);
    step();
    idle();
    ex_ready = 0;
    step();
    chk("rs_stall_valid", 32'(ex_valid), 1);
    reset = 1;
    #1;
    chk("rs_valid", 32'(ex_valid), 0);
    chk("rs_d1", data1, 0);
    chk("rs_rd", 32'(ex_rd), 0);
    chk("rs_illegal", 32'(illegal), 0);
    step();
    reset = 0; ex_ready = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      if (reset) begin
        reset = 0;
      end else if ($urandom_range(0, 399) == 0) begin
        reset = 1;
      end
      begin : rnd
        logic [6:0] opcs [8];
        int sel;
        opcs[0] = 7'b0110011; opcs[1] = 7'b0010011; opcs[2] = 7'b0000011;
        opcs[3] = 7'b0100011; opcs[4] = 7'b0110111; opcs[5] = 7'b0010111;
        opcs[6] = 7'b0110011; opcs[7] = 7'b1110011;
        sel = $urandom_range(0, 19);
        id_opcode = (sel < 8) ? opcs[sel] : (sel < 18) ? opcs[sel % 6] : 7'($urandom);
        sel = $urandom_range(0, 9);
        id_funct3 = (sel < 4) ? 3'b000 : (sel < 6) ? 3'b110 : (sel < 8) ? 3'b111 : 3'($urandom);
        sel = $urandom_range(0, 9);
        id_funct7 = (sel < 6) ? 7'h00 : (sel < 9) ? 7'h20 : 7'($urandom);
      end
      id_valid      = ($urandom_range(0, 9) < 8);
      id_rd         = 5'($urandom_range(0, 7));
      id_rs1        = 5'($urandom_range(0, 7));
      id_rs2        = 5'($urandom_range(0, 7));
      id_rs1_data   = $urandom;
      id_rs2_data   = $urandom;
      id_imm        = $urandom;
      id_pc         = $urandom;
      fwd_mem_valid = 1'($urandom);
      fwd_mem_rd    = 5'($urandom_range(0, 7));
      fwd_mem_data  = $urandom;
      fwd_wb_valid  = 1'($urandom);
      fwd_wb_rd     = 5'($urandom_range(0, 7));
      fwd_wb_data   = $urandom;
      ex_ready      = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 19) == 0);
    end
    idle();
    reset = 0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
